// File: rtl/aes_pipeline_scheduler.sv
// ---------------------------------------------------------------------------
// aes_pipeline_scheduler
//   Shares one fixed-latency AES datapath between an encrypt and a decrypt
//   requester. The scheduler picks one request per cycle round-robin, issues
//   it to the datapath, tracks the {mode, tag} of each issue through a
//   LATENCY-deep shift register and writes the result into a response FIFO.
//   Issues are credit-limited: every in-flight result already owns a FIFO
//   slot, so the FIFO can never overflow.
//
// Ports
//   clock, reset            sole clock; asynchronous active-low reset
//   enc_valid/ready/tag/data encrypt request handshake
//   dec_valid/ready/tag/data decrypt request handshake
//   dp_issue, dp_mode, dp_in datapath input (mode 0 = encrypt, 1 = decrypt)
//   dp_out                  datapath result, LATENCY cycles after issue
//   resp_valid/ready        response handshake (head of FIFO)
//   resp_mode/tag/data      head response contents
//   drain_req, drained      stop granting; drain complete indication
// ---------------------------------------------------------------------------
module aes_pipeline_scheduler #(
  parameter int LATENCY    = 11,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enc_valid,
  output logic               enc_ready,
  input  logic [TAG_W-1:0]   enc_tag,
  input  logic [127:0]       enc_data,
  input  logic               dec_valid,
  output logic               dec_ready,
  input  logic [TAG_W-1:0]   dec_tag,
  input  logic [127:0]       dec_data,
  output logic               dp_issue,
  output logic               dp_mode,
  output logic [127:0]       dp_in,
  input  logic [127:0]       dp_out,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_mode,
  output logic [TAG_W-1:0]   resp_tag,
  output logic [127:0]       resp_data,
  input  logic               drain_req,
  output logic               drained
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;            // holds 0..FIFO_DEPTH
  localparam int EW = 1 + TAG_W + 128;   // FIFO entry {mode, tag, data}

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     fifo_cnt, fly_cnt, credit;
  logic              last_enc;           // encrypt won the previous grant
  logic              grant_e, grant_d;

  logic [LATENCY-1:0] trk_v;
  logic               trk_m [LATENCY];
  logic [TAG_W-1:0]   trk_t [LATENCY];

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [EW-1:0]     head;
  logic              push, pop;

  // Every issued-but-unpopped result holds one credit.
  assign credit = CW'(FIFO_DEPTH) - fifo_cnt - fly_cnt;

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant_e   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      RUN: begin
        if (drain_req) state_nxt = DRAIN;
        // reset gates the grant so ready/issue are low while reset is held.
        if (reset && credit != '0) begin
          if (enc_valid && dec_valid) begin
            grant_e = ~last_enc;
            grant_d =  last_enc;
          end else begin
            grant_e = enc_valid;
            grant_d = dec_valid;
          end
        end
      end
      DRAIN: begin
        if (!drain_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign enc_ready = grant_e;
  assign dec_ready = grant_d;
  assign dp_issue  = grant_e | grant_d;
  assign dp_mode   = grant_d;
  assign dp_in     = grant_d ? dec_data : enc_data;

  assign push = trk_v[LATENCY-1];
  assign pop  = resp_valid & resp_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      last_enc <= 1'b0;
      trk_v    <= '0;
      fifo_cnt <= '0;
      fly_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (dp_issue) last_enc <= grant_e;
      trk_v    <= {trk_v[LATENCY-2:0], dp_issue};
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      fly_cnt  <= fly_cnt + CW'(dp_issue) - CW'(push);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: tracker payload and FIFO storage are not reset; they are only
  // observed when the matching valid bit / occupancy says so.
  always_ff @(posedge clock) begin
    trk_m[0] <= dp_mode;
    trk_t[0] <= grant_d ? dec_tag : enc_tag;
    for (int i = 1; i < LATENCY; i++) begin
      trk_m[i] <= trk_m[i-1];
      trk_t[i] <= trk_t[i-1];
    end
    if (push) mem[wr_ptr] <= {trk_m[LATENCY-1], trk_t[LATENCY-1], dp_out};
  end

  assign head       = mem[rd_ptr];
  assign resp_valid = (fifo_cnt != '0);
  // Zero the head fields when empty so stale storage never shows.
  assign resp_mode  = resp_valid ? head[EW-1] : 1'b0;
  assign resp_tag   = resp_valid ? head[EW-2 -: TAG_W] : '0;
  assign resp_data  = resp_valid ? head[127:0] : '0;

  assign drained = (state == DRAIN) && (trk_v == '0) && (fifo_cnt == '0);

endmodule

// File: tb/tb_aes_pipeline_scheduler.sv
// ---------------------------------------------------------------------------
// tb_aes_pipeline_scheduler
//   Randomized and directed stimulus against a transaction-level reference:
//   a queue of outstanding results, each stamped with the first cycle it may
//   appear, plus the round-robin, credit and drain rules. A stand-in datapath
//   returns a mode-dependent transform of dp_in after LATENCY cycles.
// ---------------------------------------------------------------------------
module tb_aes_pipeline_scheduler;

  localparam int L     = 11;
  localparam int DEPTH = 4;
  localparam int TW    = 4;
  localparam logic [127:0] KE = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] KD = 128'h13579bdf2468ace0fdb97531eca86420;

  logic           clock = 1'b0;
  logic           reset;
  logic           enc_valid, dec_valid, resp_ready, drain_req;
  logic [TW-1:0]  enc_tag, dec_tag;
  logic [127:0]   enc_data, dec_data;
  logic           enc_ready, dec_ready, dp_issue, dp_mode;
  logic [127:0]   dp_in, dp_out;
  logic           resp_valid, resp_mode, drained;
  logic [TW-1:0]  resp_tag;
  logic [127:0]   resp_data;

  aes_pipeline_scheduler #(.LATENCY(L), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset),
    .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_tag(enc_tag), .enc_data(enc_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_tag(dec_tag), .dec_data(dec_data),
    .dp_issue(dp_issue), .dp_mode(dp_mode), .dp_in(dp_in), .dp_out(dp_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_mode(resp_mode),
    .resp_tag(resp_tag), .resp_data(resp_data),
    .drain_req(drain_req), .drained(drained)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] xf(input logic mode, input logic [127:0] d);
    return mode ? ({d[63:0], d[127:64]} ^ KD) : (d ^ KE);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in datapath: fixed latency, cleared by the shared reset, garbage
  // in slots that carry no issue.
  logic [127:0] pipe [L];
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < L; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= dp_issue ? xf(dp_mode, dp_in) : rnd128();
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign dp_out = pipe[L-1];

  // Reference model
  typedef struct {
    logic          mode;
    logic [TW-1:0] tag;
    logic [127:0]  data;
    int            vis_cyc;   // first cycle the response may be visible
  } resp_t;

  resp_t q[$];
  bit    m_run      = 1'b1;
  bit    m_last_enc = 1'b0;
  int    cyc        = 0;
  int    issue_cnt  = 0;

  always @(negedge clock) begin
    if (!reset) begin
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_enc_ready", enc_ready, 1'b0);
      check("rst_dp_issue", dp_issue, 1'b0);
      check("rst_drained", drained, 1'b0);
      check("rst_resp_data", resp_data, '0);
      q.delete();
      m_run      = 1'b1;
      m_last_enc = 1'b0;
    end else begin
      int    credit;
      bit    can, we, wd, rv;
      resp_t r;
      credit = DEPTH - q.size();
      can = m_run && credit > 0;
      we  = can && enc_valid && (!dec_valid || !m_last_enc);
      wd  = can && dec_valid && (!enc_valid || m_last_enc);
      check("enc_ready", enc_ready, we);
      check("dec_ready", dec_ready, wd);
      check("dp_issue", dp_issue, we | wd);
      if (we | wd) begin
        check("dp_mode", dp_mode, wd);
        check("dp_in", dp_in, wd ? dec_data : enc_data);
      end
      rv = q.size() > 0 && q[0].vis_cyc <= cyc;
      check("resp_valid", resp_valid, rv);
      if (rv) begin
        check("resp_mode", resp_mode, q[0].mode);
        check("resp_tag", resp_tag, q[0].tag);
        check("resp_data", resp_data, q[0].data);
      end
      check("drained", drained, !m_run && q.size() == 0);
      if (dp_issue) issue_cnt++;
      if (rv && resp_ready) void'(q.pop_front());
      if (we | wd) begin
        r.mode    = wd;
        r.tag     = wd ? dec_tag : enc_tag;
        r.data    = xf(wd, wd ? dec_data : enc_data);
        r.vis_cyc = cyc + L + 1;
        q.push_back(r);
        m_last_enc = we;
      end
      m_run = !drain_req;
    end
    cyc++;
  end

  // Apply one cycle of inputs (fresh random data/tags), then advance.
  task automatic drive(input bit ev, input bit dv, input bit rr, input bit dr);
    enc_valid  = ev;
    dec_valid  = dv;
    resp_ready = rr;
    drain_req  = dr;
    enc_tag    = TW'($urandom);
    dec_tag    = TW'($urandom);
    enc_data   = rnd128();
    dec_data   = rnd128();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    enc_valid = 1'b1; dec_valid = 1'b0; resp_ready = 1'b0; drain_req = 1'b0;
    enc_tag = '0; dec_tag = '0; enc_data = '0; dec_data = '0;
    #3;
    check("async_rst_enc_ready", enc_ready, 1'b0);
    check("async_rst_resp_valid", resp_valid, 1'b0);
    check("async_rst_resp_tag", resp_tag, '0);
    enc_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Single encrypt with tag 3; model expects resp_valid 12 cycles later.
    enc_valid = 1'b1; dec_valid = 1'b0; resp_ready = 1'b1; drain_req = 1'b0;
    enc_tag = 4'd3; enc_data = rnd128(); dec_data = rnd128();
    @(posedge clock); #1;
    repeat (16) drive(0, 0, 1, 0);

    // Both requesters continuously valid: alternation and credit stall.
    repeat (60) drive(1, 1, 1, 0);
    repeat (20) drive(0, 0, 1, 0);

    // Consumer stalled: exactly DEPTH issues, then one per pop.
    issue_cnt = 0;
    repeat (20) drive(1, 0, 0, 0);
    check("stall_issue_count", issue_cnt, DEPTH);
    issue_cnt = 0;
    drive(1, 0, 1, 0);
    repeat (15) drive(1, 0, 0, 0);
    check("one_pop_one_issue", issue_cnt, 1);
    repeat (30) drive(0, 0, 1, 0);

    // Drain with two in flight.
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    drive(0, 0, 0, 1);
    issue_cnt = 0;
    repeat (15) drive(1, 1, 0, 1);
    check("drain_no_grants", issue_cnt, 0);
    repeat (4) drive(1, 1, 1, 1);
    check("drained_set", drained, 1'b1);
    drive(1, 1, 1, 0);
    check("resume_grant", enc_ready | dec_ready, 1'b1);
    repeat (30) drive(0, 0, 1, 0);

    // Randomized traffic with occasional drain windows.
    begin
      bit dr = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(99) < 3) dr = ~dr;
        drive($urandom_range(99) < 60, $urandom_range(99) < 60,
              $urandom_range(99) < 70, dr);
      end
    end
    repeat (30) drive(0, 0, 1, 0);

    // Reset with three in flight and one buffered.
    repeat (4) drive(1, 0, 0, 0);
    repeat (8) drive(0, 0, 0, 0);
    check("pre_reset_resp_valid", resp_valid, 1'b1);
    reset = 1'b0;
    #1;
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_resp_data", resp_data, '0);
    repeat (2) drive(0, 0, 1, 0);
    reset = 1'b1;
    drive(1, 0, 1, 0);
    repeat (20) drive(0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
